// File: rtl/pending_irq_controller_pkg.sv
// Shared widths, state encoding and helpers for the pending interrupt controller.
package pending_irq_controller_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef logic [N-1:0]     vec_t;
  typedef logic [IDX_W-1:0] id_t;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  function automatic vec_t id_onehot(input id_t id);
    vec_t v;
    v = {{(N-1){1'b0}}, 1'b1};
    return v << id;
  endfunction

endpackage

// File: rtl/pending_irq_controller_if.sv
// Request/handshake bundle between an interrupt source side and the controller.
interface pending_irq_controller_if;
  import pending_irq_controller_pkg::*;

  vec_t req;
  vec_t mask;
  logic irq_ack;
  logic clr_overflow;
  logic irq_valid;
  id_t  irq_id;
  vec_t pending;
  logic overflow;

  modport master (
    output req, mask, irq_ack, clr_overflow,
    input  irq_valid, irq_id, pending, overflow
  );

  modport slave (
    input  req, mask, irq_ack, clr_overflow,
    output irq_valid, irq_id, pending, overflow
  );

endinterface

// File: rtl/pending_irq_controller_enc.sv
// Combinational 8-to-3 priority encoder, highest set index wins; all-zero input yields 0.
module eight_to_three_priority_encoder
  import pending_irq_controller_pkg::*;
(
  input  vec_t x,
  output id_t  f
);

  // Priority selection
  always_comb begin
    f = 3'd0;
    casez (x)
      8'b1???????: f = 3'd7;
      8'b01??????: f = 3'd6;
      8'b001?????: f = 3'd5;
      8'b0001????: f = 3'd4;
      8'b00001???: f = 3'd3;
      8'b000001??: f = 3'd2;
      8'b0000001?: f = 3'd1;
      8'b00000001: f = 3'd0;
      default:     f = 3'd0;
    endcase
  end

endmodule

// File: rtl/pending_irq_controller.sv
// Edge-captures request lines into a pending register and presents the highest
// enabled pending index through a valid/ack handshake.
module pending_irq_controller
  import pending_irq_controller_pkg::*;
(
  input logic clk,
  input logic rst,
  pending_irq_controller_if.slave bus
);

  logic [0:0] r_state;
  vec_t       r_req_q;
  vec_t       r_pending;
  logic       r_irq_valid;
  id_t        r_irq_id;
  logic       r_overflow;

  vec_t w_rise;
  vec_t w_cand;
  vec_t w_clr;
  vec_t w_pending_nxt;
  id_t  w_enc_id;
  logic w_ack_fire;
  logic w_ovf_set;

  assign w_rise = bus.req & ~r_req_q;
  assign w_cand = r_pending & bus.mask;

  eight_to_three_priority_encoder u_enc (
    .x (w_cand),
    .f (w_enc_id)
  );

  // Clear vector from an accepted ack; a same-cycle rise on that bit wins over the clear
  always_comb begin
    w_ack_fire = (r_state == ST_PRESENT) && bus.irq_ack;
    if (w_ack_fire) begin
      w_clr = id_onehot(r_irq_id);
    end else begin
      w_clr = {N{1'b0}};
    end
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    w_ovf_set     = |(w_rise & r_pending & ~w_clr);
  end

  // Edge-detect history and pending register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q   <= {N{1'b0}};
      r_pending <= {N{1'b0}};
    end else begin
      r_req_q   <= bus.req;
      r_pending <= w_pending_nxt;
    end
  end

  // Sticky overflow: a lost edge beats a simultaneous clear request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Presentation FSM; the ID is frozen while presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_irq_valid <= 1'b0;
      r_irq_id    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand != {N{1'b0}}) begin
            r_irq_id    <= w_enc_id;
            r_irq_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end else begin
            r_irq_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (w_ack_fire) begin
            r_irq_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_irq_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        default: begin
          r_irq_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.irq_valid = r_irq_valid;
  assign bus.irq_id    = r_irq_id;
  assign bus.pending   = r_pending;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_pending_irq_controller.sv
// Directed and random checks of pending_irq_controller against a behavioural model.
module tb_pending_irq_controller;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pending_irq_controller_if bus ();

  pending_irq_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state
  bit [7:0] m_pend;
  bit [7:0] m_prev_req;
  bit       m_valid;
  bit       m_ovf;
  int       m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 8'h00; m_prev_req = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_id = 0;
  endtask

  // Applies the interrupt rules for one clock using the inputs currently driven.
  task automatic model_step();
    bit [7:0] nxt;
    bit       lost;
    bit       served;
    lost = 1'b0;
    served = m_valid && bus.irq_ack;
    for (int i = 0; i < 8; i++) begin
      bit rose;
      bit cleared;
      rose    = bus.req[i] && !m_prev_req[i];
      cleared = served && (i == m_id);
      if (rose && m_pend[i] && !cleared) lost = 1'b1;
      nxt[i] = rose ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
    end
    if (lost) m_ovf = 1'b1;
    else if (bus.clr_overflow) m_ovf = 1'b0;
    if (m_valid) begin
      if (served) m_valid = 1'b0;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (!m_valid && m_pend[i] && bus.mask[i]) begin
          m_valid = 1'b1;
          m_id = i;
        end
      end
    end
    m_pend = nxt;
    m_prev_req = bus.req;
  endtask

  task automatic cmp_model();
    chk("valid", 32'(bus.irq_valid), 32'(m_valid));
    if (m_valid) chk("id", 32'(bus.irq_id), 32'(m_id));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  // Waits (bounded) for a presentation, checks its ID and latency, then acks it.
  task automatic serve(input int exp_id, input int exp_wait);
    int n;
    n = 0;
    while (!bus.irq_valid && n < 20) begin
      tick();
      n++;
    end
    chk("serve_valid", 32'(bus.irq_valid), 32'd1);
    chk("serve_id", 32'(bus.irq_id), 32'(exp_id));
    chk("serve_wait", 32'(n), 32'(exp_wait));
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] pat);
    bus.req = pat;
    tick();
    bus.req = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.req = 8'h00; bus.mask = 8'hFF; bus.irq_ack = 1'b0; bus.clr_overflow = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_model();
    rst = 1'b0;

    // acks while idle are ignored
    bus.irq_ack = 1'b1;
    repeat (3) tick();
    bus.irq_ack = 1'b0;
    chk("idle_ack_valid", 32'(bus.irq_valid), 32'd0);

    // priority order 7,3,1,0 with one idle cycle between grants
    pulse(8'b10001011);
    serve(7, 1);
    serve(3, 1);
    serve(1, 1);
    serve(0, 1);
    chk("drained", 32'(bus.pending), 32'd0);

    // masked lines stay pending until enabled
    bus.mask = 8'b00001111;
    pulse(8'b01100010);
    serve(1, 1);
    repeat (3) tick();
    chk("masked_pend", 32'(bus.pending), 32'h60);
    chk("masked_valid", 32'(bus.irq_valid), 32'd0);
    bus.mask = 8'hFF;
    serve(6, 1);
    serve(5, 1);

    // presented ID is not replaced by a later higher-priority edge
    pulse(8'b00000100);
    tick();
    chk("hold_id_a", 32'(bus.irq_id), 32'd2);
    pulse(8'b01000000);
    repeat (2) tick();
    chk("hold_id_b", 32'(bus.irq_id), 32'd2);
    serve(2, 0);
    serve(6, 1);

    // overflow on re-rise, clear, then ack racing a rise of the same line
    pulse(8'b00001000);
    tick();
    chk("ov_id", 32'(bus.irq_id), 32'd3);
    pulse(8'b00001000);
    chk("ov_set", 32'(bus.overflow), 32'd1);
    repeat (2) tick();
    chk("ov_sticky", 32'(bus.overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("ov_clr", 32'(bus.overflow), 32'd0);
    bus.irq_ack = 1'b1;
    bus.req = 8'b00001000;
    tick();
    bus.irq_ack = 1'b0;
    bus.req = 8'h00;
    chk("race_pend", 32'(bus.pending[3]), 32'd1);
    chk("race_ov", 32'(bus.overflow), 32'd0);
    serve(3, 1);

    // asynchronous reset while presenting ID 4, with req held through release
    bus.req = 8'b00010000;
    tick();
    tick();
    chk("pre_rst_id", 32'(bus.irq_id), 32'd4);
    bus.req = 8'h00;
    tick();
    bus.req = 8'b00010000;
    tick();
    chk("pre_rst_ov", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.irq_valid), 32'd0);
    chk("arst_pend", 32'(bus.pending), 32'd0);
    chk("arst_ov", 32'(bus.overflow), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rel_valid0", 32'(bus.irq_valid), 32'd0);
    tick();
    chk("rel_valid1", 32'(bus.irq_valid), 32'd1);
    chk("rel_id", 32'(bus.irq_id), 32'd4);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bus.req = 8'($urandom & $urandom);
      bus.mask = 8'($urandom | $urandom);
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      bus.clr_overflow = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
